// File: rtl/l2_arbiter.sv
// l2_arbiter: shares one L2 port between the L1 I-cache (read-only) and the
// L1 D-cache (read/write). Grants one requester at a time, alternating on
// ties, latches the winning request and forwards it to L2 until l2_resp.
// The response pulse goes back to the winner only.
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   i_read, i_address            I-cache request (held until i_resp)
//   i_rdata, i_resp              I-cache read line / completion pulse
//   d_read, d_write, d_address,  D-cache request (held until d_resp)
//   d_wdata
//   d_rdata, d_resp              D-cache read line / completion pulse
//   l2_read, l2_write,           latched request towards L2
//   l2_address, l2_wdata
//   l2_rdata, l2_resp            L2 read data / completion pulse
module l2_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t                state, state_nxt;
  logic                  op_read, op_write;
  logic                  last_d;   // 1: last grant went to the D-cache
  logic                  abort;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;

  logic d_req, grant_i, grant_d, drop, busy;

  assign d_req = d_read | d_write;

  // Tie goes to whoever did not win last time.
  assign grant_i = (state == IDLE) && i_read && (!d_req || last_d);
  assign grant_d = (state == IDLE) && d_req && (!i_read || !last_d);

  // Winner withdrew its request while L2 is still working on it.
  assign drop = ((state == SERVE_I) && !i_read) ||
                ((state == SERVE_D) && !d_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_read  <= 1'b0;
      op_write <= 1'b0;
      last_d   <= 1'b1;
      abort    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state <= state_nxt;
      if (grant_i) begin
        addr_q   <= i_address;
        wdata_q  <= '0;
        op_read  <= 1'b1;
        op_write <= 1'b0;
        last_d   <= 1'b0;
        abort    <= 1'b0;
      end else if (grant_d) begin
        addr_q   <= d_address;
        wdata_q  <= d_wdata;
        // read+write together is illegal; the write wins
        op_read  <= ~d_write;
        op_write <= d_write;
        last_d   <= 1'b1;
        abort    <= 1'b0;
      end else if (drop && !l2_resp) begin
        abort <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    unique case (state)
      IDLE: begin
        // l2_resp here is spurious and ignored
        if (grant_i)      state_nxt = SERVE_I;
        else if (grant_d) state_nxt = SERVE_D;
      end
      SERVE_I: begin
        busy   = 1'b1;
        i_resp = l2_resp & ~abort;
        if (l2_resp) state_nxt = IDLE;
      end
      SERVE_D: begin
        busy   = 1'b1;
        d_resp = l2_resp & ~abort;
        if (l2_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request stays up through an abort so L2 is never cut off mid-transaction.
  assign l2_read    = busy & op_read;
  assign l2_write   = busy & op_write;
  assign l2_address = addr_q;
  assign l2_wdata   = wdata_q;

  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

endmodule
